pipe_funnel_rr: RTL and testbench
=================================

// Module: pipe_funnel_rr
// PURPOSE
//  Registered, fair N:1 funnel; merges funnelWidth enq sources into one enq sink.
//  Binary tree of 2:1 nodes; one output register per node; round-robin grant per node.
//  Sits between per-channel producers (request ports, DMA lanes) and a shared
//  consumer (FIFO, serializer).
//  Successor to the combinational fixed-priority funnel: adds pipelining, fairness
//  and non-power-of-2 widths.
// PARAMETERS
//  funnelWidth  8   number of input channels, >=1, any value (padded to 2**LEVELS internally)
//  dataWidth    32  payload bits per channel
//  LEVELS       localparam = (funnelWidth==1) ? 1 : $clog2(funnelWidth); tree depth and latency
// PORTS
//  CLK              in   1                     clock, all state on posedge
//  nRST             in   1                     asynchronous active-low reset
//  input$enq__ENA   in   funnelWidth           per-channel enq strobe; legal only while matching RDY=1
//  input$enq$v      in   dataWidth*funnelWidth channel j at bits [(j+1)*dataWidth-1 : j*dataWidth]
//  input$enq__RDY   out  funnelWidth           channel j may enq this cycle
//  output$enq__ENA  out  1                     transfer to sink; asserted only while output$enq__RDY=1
//  output$enq$v     out  dataWidth             payload of the transfer
//  output$enq__RDY  in   1                     sink can accept this cycle
// BEHAVIOUR
//  - Reset (async assert on nRST=0, sync release):
//    every node valid=0, data=0, prio=0 (prio=0 prefers the lower index);
//    output$enq__ENA=0, output$enq$v=0.
//    In-flight beats are discarded; input$enq__RDY goes 1 on the first clock edge after release.
//  - Node state: valid, data, prio. Node output ready: oRdy = !valid || downRdy.
//    Root downRdy = output$enq__RDY.
//  - Grant, evaluated while oRdy=1:
//    - only one request -> grant it.
//    - both requesting  -> grant the side selected by prio, then prio <= !granted side.
//    - prio changes only on a contested grant.
//  - Upstream RDY, left (2j) and right (2j+1) of a node:
//    - RDY = oRdy && (!otherReq || prio selects this side).
//    - Right/left requests are ENA of the child (input level) or child valid (inner levels).
//  - Latency: exactly LEVELS cycles from input ENA to output$enq__ENA when no backpressure.
//  - Throughput: 1 beat/cycle sustained. Ready path is combinational root->leaf
//    (depth LEVELS); no skid buffer.
//  - Node pop: valid clears on a downstream transfer unless a new grant lands
//    in the same cycle; simultaneous pop+grant keeps valid=1 with the new data.
//  - output$enq__ENA = root.valid && output$enq__RDY.
//  - output$enq$v = root.data (held stable while valid and not transferred).
//  - Padding: channels >= funnelWidth are tied ENA=0 and never granted.
//    funnelWidth=1 is one register stage.
//  - Order: beats from one channel leave in issue order; no ordering across channels.
//  - Fairness: with all N channels continuously requesting, each channel gets exactly
//    1 of every N outputs (N=power of 2).
//  - No loss, no duplication: every input transfer appears exactly once on the output.
// CONFIGURATION
//  FUNNEL_SOURCE_ID_EN defined:
//    - extra port output$enq$src (out, SRCW=LEVELS bits) = originating channel index.
//    - Carried per node as {child_src, side} alongside data; reset 0; valid with output$enq__ENA.
//  Not defined:
//    - port and src registers are absent; behaviour otherwise identical.
// STRUCTURE
//  - Package funnel_pkg:
//    - function funnel_levels(int w) returning LEVELS;
//    - typedef funnel_prio_e {PRIO_LEFT=0, PRIO_RIGHT=1};
//    - localparam FUNNEL_RST_DATA='0.
//  - Sub-module funnel_rr_node #(dataWidth, SRCW): one 2:1 registered round-robin node.
//  - Top: generate over levels/nodes, leaf padding, root mapping, optional src.
// TESTING
//  1 reset: hold nRST=0 with all ENA=1 -> output$enq__ENA=0, output$enq$v=0, no state change;
//    release -> RDY=all 1s after 1 edge.
//  2 single channel: W=8, ch5 enq 0xA5 once -> output 0xA5 exactly 3 cycles later
//    (src=5 with FUNNEL_SOURCE_ID_EN); no other output.
//  3 contention: all 8 channels enq (value = 0x100+ch) every cycle, sink always ready,
//    64 cycles -> each value seen 8 times; no channel is granted twice before every
//    other channel has been granted once.
//  4 backpressure: output$enq__RDY=0 for 10 cycles mid-stream -> output$enq$v stable,
//    input RDY drops within the tree depth; resume -> no loss or duplication
//    (scoreboard per channel).
//  5 non-pow2: W=5, ch4 and ch0 saturated -> ch4 and ch0 alternate 1:1; padded slots 5..7
//    never appear.
//  6 reset mid-flight: assert nRST with 3 beats in tree -> ENA drops immediately
//    (async), nothing emitted after release.

Source files
------------

// File: rtl/funnel_pkg.sv
// funnel_pkg: shared types, constants and depth helper for the round-robin funnel
package funnel_pkg;

    typedef enum logic {PRIO_LEFT = 1'b0, PRIO_RIGHT = 1'b1} funnel_prio_e;

    localparam logic FUNNEL_RST_DATA = 1'b0;

    function automatic int funnel_levels(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/funnel_rr_node.sv
// funnel_rr_node: one registered 2:1 round-robin merge stage
// Payload is {src, data}; SRCW is 0 when source ids are not carried.
module funnel_rr_node
    import funnel_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int SRCW      = 0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_l,
    input  logic                      req_r,
    input  logic [dataWidth+SRCW-1:0] pay_l,
    input  logic [dataWidth+SRCW-1:0] pay_r,
    input  logic                      down_rdy,
    output logic                      rdy_l,
    output logic                      rdy_r,
    output logic                      valid,
    output logic [dataWidth+SRCW-1:0] pay
);

    localparam int PW = dataWidth + SRCW;

    funnel_prio_e prio;
    logic         o_rdy;
    logic         gnt_l;
    logic         gnt_r;

    assign o_rdy = !valid || down_rdy;
    assign rdy_l = o_rdy && (!req_r || prio == PRIO_LEFT);
    assign rdy_r = o_rdy && (!req_l || prio == PRIO_RIGHT);
    assign gnt_l = req_l && rdy_l;
    assign gnt_r = req_r && rdy_r;

    // a grant landing on the same edge as a pop keeps the stage full
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            pay   <= {PW{FUNNEL_RST_DATA}};
            prio  <= PRIO_LEFT;
        end else begin
            if (gnt_l || gnt_r) begin
                valid <= 1'b1;
                pay   <= gnt_r ? pay_r : pay_l;
            end else if (down_rdy) begin
                valid <= 1'b0;
            end
            if (o_rdy && req_l && req_r)
                prio <= gnt_l ? PRIO_RIGHT : PRIO_LEFT;
        end
    end

endmodule

// File: rtl/pipe_funnel_rr.sv
// pipe_funnel_rr: pipelined fair N:1 funnel built from a tree of registered round-robin nodes
module pipe_funnel_rr
  import funnel_pkg::*;
#(
  parameter  int funnelWidth = 8,
  parameter  int dataWidth   = 32,
  localparam int LEVELS      = funnel_levels(funnelWidth)
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [funnelWidth-1:0]           input_enq__ENA,
  input  logic [dataWidth*funnelWidth-1:0] input_enq_v,
  output logic [funnelWidth-1:0]           input_enq__RDY,
  output logic                             output_enq__ENA,
  output logic [dataWidth-1:0]             output_enq_v,
`ifdef FUNNEL_SOURCE_ID_EN
  output logic [LEVELS-1:0]                output_enq_src,
`endif
  input  logic                             output_enq__RDY
);
  localparam int P = 2 ** LEVELS;
`ifdef FUNNEL_SOURCE_ID_EN
  localparam int SRCW = LEVELS;
`else
  localparam int SRCW = 0;
`endif
  localparam int PW = dataWidth + SRCW;
  logic          req [1:2*P-1];
  logic          rdy [1:2*P-1];
  logic [PW-1:0] pay [1:2*P-1];
  logic          live;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) live <= 1'b0;
    else live <= 1'b1;
  genvar i;
  for (i = P; i < 2 * P; i++) begin : g_leaf
    if (i - P < funnelWidth) begin : g_ch
      assign req[i] = input_enq__ENA[i-P] && live;
`ifdef FUNNEL_SOURCE_ID_EN
      assign pay[i] = {SRCW'(i - P), input_enq_v[(i-P)*dataWidth +: dataWidth]};
`else
      assign pay[i] = input_enq_v[(i-P)*dataWidth +: dataWidth];
`endif
      assign input_enq__RDY[i-P] = rdy[i] && live;
    end else begin : g_pad
      assign req[i] = 1'b0;
      assign pay[i] = {PW{FUNNEL_RST_DATA}};
    end
  end
  for (i = 1; i < P; i++) begin : g_node
    funnel_rr_node #(.dataWidth(dataWidth), .SRCW(SRCW)) u_node (
      .CLK      (CLK),
      .nRST     (nRST),
      .req_l    (req[2*i]),
      .req_r    (req[2*i+1]),
      .pay_l    (pay[2*i]),
      .pay_r    (pay[2*i+1]),
      .down_rdy (rdy[i]),
      .rdy_l    (rdy[2*i]),
      .rdy_r    (rdy[2*i+1]),
      .valid    (req[i]),
      .pay      (pay[i])
    );
  end
  assign rdy[1]          = output_enq__RDY;
  assign output_enq__ENA = req[1] && output_enq__RDY;
  assign output_enq_v    = pay[1][dataWidth-1:0];
`ifdef FUNNEL_SOURCE_ID_EN
  assign output_enq_src  = pay[1][PW-1:dataWidth];
`endif
endmodule

// File: tb/tb_pipe_funnel_rr.sv
// tb_pipe_funnel_rr: directed checks of the funnel at widths 8 and 5
module tb_pipe_funnel_rr;
  logic         CLK = 1'b0;
  logic         nRST;
  logic [7:0]   ena8, rdy8;
  logic [255:0] v8;
  logic         o_ena8, o_rdy8;
  logic [31:0]  o_v8;
  logic [4:0]   ena5, rdy5;
  logic [159:0] v5;
  logic         o_ena5, o_rdy5;
  logic [31:0]  o_v5;
`ifdef FUNNEL_SOURCE_ID_EN
  logic [2:0]   src8, src5;
`endif
  int n_chk, n_pass;
  int sent[8];
  int exp_seq[8];
  int outs[$];
  bit mon, sel;
  always #5 CLK = ~CLK;
  pipe_funnel_rr #(.funnelWidth(8), .dataWidth(32)) dut8 (
    .CLK(CLK), .nRST(nRST),
    .input_enq__ENA(ena8), .input_enq_v(v8), .input_enq__RDY(rdy8),
    .output_enq__ENA(o_ena8), .output_enq_v(o_v8),
`ifdef FUNNEL_SOURCE_ID_EN
    .output_enq_src(src8),
`endif
    .output_enq__RDY(o_rdy8)
  );
  pipe_funnel_rr #(.funnelWidth(5), .dataWidth(32)) dut5 (
    .CLK(CLK), .nRST(nRST),
    .input_enq__ENA(ena5), .input_enq_v(v5), .input_enq__RDY(rdy5),
    .output_enq__ENA(o_ena5), .output_enq_v(o_v5),
`ifdef FUNNEL_SOURCE_ID_EN
    .output_enq_src(src5),
`endif
    .output_enq__RDY(o_rdy5)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  task automatic clear_sb();
    for (int j = 0; j < 8; j++) begin
      sent[j] = 0;
      exp_seq[j] = 0;
    end
    outs.delete();
  endtask
  task automatic drive();
    for (int j = 0; j < 8; j++) v8[j*32 +: 32] = {sent[j][15:0], 8'h01, 8'(j)};
    for (int j = 0; j < 5; j++) v5[j*32 +: 32] = {sent[j][15:0], 8'h01, 8'(j)};
  endtask
  task automatic monitor();
    logic [7:0]  e, r;
    logic        oe;
    logic [31:0] ov;
    int          w, ch;
    if (!mon) return;
    e  = sel ? {3'b0, ena5} : ena8;
    r  = sel ? {3'b0, rdy5} : rdy8;
    oe = sel ? o_ena5 : o_ena8;
    ov = sel ? o_v5 : o_v8;
    w  = sel ? 5 : 8;
    for (int j = 0; j < 8; j++) if (e[j] && r[j]) sent[j]++;
    if (oe) begin
      ch = int'(ov[7:0]);
      chk("chan_range", ch < w, 1'b1);
      if (ch < w) begin
        chk("order", ov[31:16], exp_seq[ch][15:0]);
        exp_seq[ch]++;
        outs.push_back(ch);
`ifdef FUNNEL_SOURCE_ID_EN
        chk("src", sel ? src5 : src8, ch);
`endif
      end
    end
  endtask
  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    int cnt, guard, mask;
    logic [31:0] held;
    n_chk = 0; n_pass = 0;
    mon = 0; sel = 0;
    nRST = 1'b0;
    ena8 = '1; v8 = '0; o_rdy8 = 1'b1;
    ena5 = '0; v5 = '0; o_rdy5 = 1'b1;
    clear_sb();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_oena", o_ena8, 0);
    chk("rst_ov", o_v8, 0);
    chk("rst_rdy", rdy8, 0);
    ena8 = '0;
    nRST = 1'b1;
    #1;
    chk("rel_rdy_before_edge", rdy8, 0);
    @(posedge CLK); #1;
    chk("rel_rdy8", rdy8, 8'hFF);
    chk("rel_rdy5", rdy5, 5'h1F);
    cnt = 0;
    repeat (4) begin
      @(negedge CLK); cnt += int'(o_ena8);
      @(posedge CLK); #1;
    end
    chk("idle_out", cnt, 0);
    ena8 = 8'h20;
    v8[5*32 +: 32] = 32'hA5;
    #1 chk("t2_rdy5", rdy8[5], 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk($sformatf("t2_lat%0d", k), o_ena8, k == 3);
      if (k == 3) begin
        chk("t2_data", o_v8, 32'hA5);
`ifdef FUNNEL_SOURCE_ID_EN
        chk("t2_src", src8, 5);
`endif
      end
      @(posedge CLK); #1;
      if (k == 0) ena8 = '0;
    end
    clear_sb(); mon = 1; sel = 0;
    ena8 = '1; drive();
    guard = 0;
    while (outs.size() < 64 && guard < 200) begin
      tick(); drive(); guard++;
    end
    chk("t3_bound", outs.size() >= 64, 1'b1);
    ena8 = '0;
    repeat (8) tick();
    if (outs.size() >= 64) begin
      for (int j = 0; j < 8; j++) begin
        cnt = 0;
        for (int k = 0; k < 64; k++) if (outs[k] == j) cnt++;
        chk($sformatf("t3_cnt%0d", j), cnt, 8);
      end
      for (int b = 0; b < 8; b++) begin
        mask = 0;
        for (int k = 0; k < 8; k++) mask |= 1 << outs[b*8 + k];
        chk($sformatf("t3_fair%0d", b), mask, 8'hFF);
      end
    end
    for (int j = 0; j < 8; j++) chk($sformatf("t3_noloss%0d", j), exp_seq[j], sent[j]);
    clear_sb();
    for (int k = 0; k < 12; k++) begin
      case (k % 4)
        0: ena8 = 8'hA5;
        1: ena8 = 8'h3C;
        2: ena8 = 8'hFF;
        default: ena8 = 8'h81;
      endcase
      drive(); tick();
    end
    ena8 = '1; drive();
    repeat (4) begin tick(); drive(); end
    o_rdy8 = 1'b0;
    held = o_v8;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      monitor();
      chk("t4_stall_ena", o_ena8, 0);
      chk("t4_hold", o_v8, held);
      if (k == 4) chk("t4_rdy_drop", rdy8, 0);
      @(posedge CLK); #1;
      drive();
    end
    o_rdy8 = 1'b1;
    repeat (8) begin tick(); drive(); end
    ena8 = '0;
    repeat (10) tick();
    for (int j = 0; j < 8; j++) chk($sformatf("t4_noloss%0d", j), exp_seq[j], sent[j]);
    clear_sb(); sel = 1;
    ena5 = 5'b10001; drive();
    guard = 0;
    while (outs.size() < 20 && guard < 100) begin
      tick(); drive(); guard++;
    end
    chk("t5_bound", outs.size() >= 20, 1'b1);
    ena5 = '0;
    repeat (8) tick();
    if (outs.size() >= 20)
      for (int k = 0; k < 20; k++) chk($sformatf("t5_alt%0d", k), outs[k], (k % 2) ? 4 : 0);
    for (int j = 0; j < 5; j++) chk($sformatf("t5_noloss%0d", j), exp_seq[j], sent[j]);
    mon = 0; sel = 0;
    o_rdy8 = 1'b0;
    ena8 = 8'h46; drive();
    @(posedge CLK); #1;
    ena8 = '0;
    repeat (4) @(posedge CLK);
    #1;
    o_rdy8 = 1'b1;
    #1 chk("t6_pre_ena", o_ena8, 1'b1);
    nRST = 1'b0;
    #1;
    chk("t6_async_ena", o_ena8, 0);
    chk("t6_async_v", o_v8, 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK); cnt += int'(o_ena8);
      @(posedge CLK); #1;
    end
    chk("t6_quiet", cnt, 0);
    chk("t6_rdy", rdy8, 8'hFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
